// File: rtl/dma_ram_port_pkg.sv
// Shared widths and channel-select encodings for the DMA RAM port.
package dma_ram_port_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 2 ** ADDR_W;

   // {load, cnn} selects which requester owns the RAM this cycle
   typedef enum logic [1:0] {
      MODE_EXT  = 2'b00,
      MODE_CNN  = 2'b01,
      MODE_DEC  = 2'b10,
      MODE_FILE = 2'b11
   } mode_e;

endpackage

// File: rtl/dma_ram_port_if.sv
// Requester channels, mode select and RAM response of the DMA RAM port.
interface dma_ram_port_if #(
   parameter int ADDR_W = dma_ram_port_pkg::ADDR_W,
   parameter int DATA_W = dma_ram_port_pkg::DATA_W
);

   logic              load;
   logic              cnn;
   logic [ADDR_W-1:0] dec_addr;
   logic [DATA_W-1:0] dec_wdata;
   logic              dec_we;
   logic              dec_re;
   logic [ADDR_W-1:0] file_addr;
   logic [DATA_W-1:0] file_wdata;
   logic              file_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_we;
   logic              ext_re;
   logic [DATA_W-1:0] ram_rdata;
   logic              done_read;
   logic              done_write;

   modport master (
      output load, cnn,
      output dec_addr, dec_wdata, dec_we, dec_re,
      output file_addr, file_wdata, file_we,
      output ext_addr, ext_wdata, ext_we, ext_re,
      input  ram_rdata, done_read, done_write
   );

   modport slave (
      input  load, cnn,
      input  dec_addr, dec_wdata, dec_we, dec_re,
      input  file_addr, file_wdata, file_we,
      input  ext_addr, ext_wdata, ext_we, ext_re,
      output ram_rdata, done_read, done_write
   );

endinterface

// File: rtl/dma_ram_core.sv
// Single-port RAM with registered read-first data and one-cycle done pulses.
module dma_ram_core #(
   parameter int ADDR_W = dma_ram_port_pkg::ADDR_W,
   parameter int DATA_W = dma_ram_port_pkg::DATA_W,
   parameter int DEPTH  = dma_ram_port_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              we,
   input  logic              re,
   output logic [DATA_W-1:0] rdata,
   output logic              doneRead,
   output logic              doneWrite
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wrEn;

   // Writes are blocked while reset is held; the array itself is never cleared.
   assign wrEn = we & RST;

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[addr] <= wdata;
      end
   end

   // Read samples the pre-write word when a write hits the same address.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         rdata     <= '0;
         doneRead  <= 1'b0;
         doneWrite <= 1'b0;
      end else begin
         doneRead  <= re;
         doneWrite <= we;
         if (re) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dma_ram_port.sv
// Four-way requester mux in front of a shared RAM core.
module dma_ram_port #(
   parameter int ADDR_W = dma_ram_port_pkg::ADDR_W,
   parameter int DATA_W = dma_ram_port_pkg::DATA_W,
   parameter int DEPTH  = dma_ram_port_pkg::DEPTH
) (
   input logic          clk,
   input logic          RST,
   dma_ram_port_if.slave bus
);

   import dma_ram_port_pkg::*;

   mode_e             mode;
   logic [ADDR_W-1:0] muxAddr;
   logic [DATA_W-1:0] muxWdata;
   logic              muxWe;
   logic              muxRe;

   assign mode = mode_e'({bus.load, bus.cnn});

   // CNN slot has no requester and leaves the RAM idle.
   always_comb begin
      muxAddr  = '0;
      muxWdata = '0;
      muxWe    = 1'b0;
      muxRe    = 1'b0;
      case (mode)
         MODE_DEC: begin
            muxAddr  = bus.dec_addr;
            muxWdata = bus.dec_wdata;
            muxWe    = bus.dec_we;
            muxRe    = bus.dec_re;
         end
         MODE_FILE: begin
            muxAddr  = bus.file_addr;
            muxWdata = bus.file_wdata;
            muxWe    = bus.file_we;
            muxRe    = 1'b0;
         end
         MODE_EXT: begin
            muxAddr  = bus.ext_addr;
            muxWdata = bus.ext_wdata;
            muxWe    = bus.ext_we;
            muxRe    = bus.ext_re;
         end
         default: begin
            muxAddr  = '0;
            muxWdata = '0;
            muxWe    = 1'b0;
            muxRe    = 1'b0;
         end
      endcase
   end

   dma_ram_core #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .clk       (clk),
      .RST       (RST),
      .addr      (muxAddr),
      .wdata     (muxWdata),
      .we        (muxWe),
      .re        (muxRe),
      .rdata     (bus.ram_rdata),
      .doneRead  (bus.done_read),
      .doneWrite (bus.done_write)
   );

endmodule

// File: tb/tb_dma_ram_port.sv
// Scoreboarded bench for dma_ram_port: directed scenarios plus randomized traffic.
module tb_dma_ram_port;

   logic clk = 1'b0;
   logic RST = 1'b0;
   always #5 clk = ~clk;

   dma_ram_port_if bus ();

   dma_ram_port dut (
      .clk (clk),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      bit         rd;
      bit         wr;
      bit         known;
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t       expQ[$];
   logic [7:0] refMem [int];
   int         checks = 0;
   int         errors = 0;
   int         writePulses = 0;
   int         cyc = 0;
   bit         monEn = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT pulses a done.
   always @(negedge clk) begin
      if (RST && monEn) begin
         while (expQ.size() > 0 && expQ[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_done: got no pulse expected rd=%0d wr=%0d (cycle %0d)",
                     expQ[0].rd, expQ[0].wr, expQ[0].due);
            void'(expQ.pop_front());
         end
         if (bus.done_write) writePulses++;
         if (bus.done_read || bus.done_write) begin
            if (expQ.size() > 0 && expQ[0].due == cyc) begin
               exp_t e;
               e = expQ.pop_front();
               check("done_read", 32'(bus.done_read), 32'(e.rd));
               check("done_write", 32'(bus.done_write), 32'(e.wr));
               if (e.rd && e.known) check("ram_rdata", 32'(bus.ram_rdata), 32'(e.data));
            end else begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got rd=%0d wr=%0d expected none (cycle %0d)",
                        bus.done_read, bus.done_write, cyc);
            end
         end
      end
   end

   task automatic clearInputs();
      bus.load = 1'b0;       bus.cnn = 1'b0;
      bus.dec_addr = '0;     bus.dec_wdata = '0;  bus.dec_we = 1'b0; bus.dec_re = 1'b0;
      bus.file_addr = '0;    bus.file_wdata = '0; bus.file_we = 1'b0;
      bus.ext_addr = '0;     bus.ext_wdata = '0;  bus.ext_we = 1'b0; bus.ext_re = 1'b0;
   endtask

   // Reference: pick the owning channel from the mode table, read old data, then update memory.
   task automatic step();
      logic [15:0] a;
      logic [7:0]  d;
      bit          w, r;
      exp_t        e;
      a = '0; d = '0; w = 1'b0; r = 1'b0;
      case ({bus.load, bus.cnn})
         2'b10: begin a = bus.dec_addr;  d = bus.dec_wdata;  w = bus.dec_we;  r = bus.dec_re; end
         2'b11: begin a = bus.file_addr; d = bus.file_wdata; w = bus.file_we; r = 1'b0;       end
         2'b00: begin a = bus.ext_addr;  d = bus.ext_wdata;  w = bus.ext_we;  r = bus.ext_re; end
         default: ;
      endcase
      if (r || w) begin
         e.rd = r;
         e.wr = w;
         e.known = 1'b0;
         e.data = 8'h00;
         if (r && refMem.exists(int'(a))) begin
            e.known = 1'b1;
            e.data = refMem[int'(a)];
         end
         e.due = cyc + 1;
         expQ.push_back(e);
      end
      if (w) refMem[int'(a)] = d;
      @(posedge clk);
      #1;
   endtask

   task automatic extWrite(input logic [15:0] a, input logic [7:0] d);
      clearInputs();
      bus.ext_addr = a; bus.ext_wdata = d; bus.ext_we = 1'b1;
      step();
      clearInputs();
   endtask

   task automatic extRead(input logic [15:0] a);
      clearInputs();
      bus.ext_addr = a; bus.ext_re = 1'b1;
      step();
      clearInputs();
   endtask

   initial begin
      int startPulses;
      clearInputs();
      monEn = 1'b1;
      #1;
      check("reset_rdata", 32'(bus.ram_rdata), 32'h0);
      check("reset_done_read", 32'(bus.done_read), 32'h0);
      check("reset_done_write", 32'(bus.done_write), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      RST = 1'b1;

      // Host write then read
      extWrite(16'h0010, 8'hA5);
      extRead(16'h0010);
      step();
      step();
      check("rdata_hold", 32'(bus.ram_rdata), 32'hA5);

      // Mux isolation
      extWrite(16'h0020, 8'h00);
      bus.load = 1'b1; bus.cnn = 1'b0;
      bus.file_addr = 16'h0020; bus.file_wdata = 8'h3C; bus.file_we = 1'b1;
      step();
      extRead(16'h0020);
      bus.load = 1'b1; bus.cnn = 1'b1;
      bus.file_addr = 16'h0020; bus.file_wdata = 8'h3C; bus.file_we = 1'b1;
      step();
      extRead(16'h0020);

      // CNN mode leaves the RAM idle
      extWrite(16'h0030, 8'h99);
      bus.load = 1'b0; bus.cnn = 1'b1;
      bus.dec_addr = 16'h0030;  bus.dec_wdata = 8'h44;  bus.dec_we = 1'b1; bus.dec_re = 1'b1;
      bus.file_addr = 16'h0030; bus.file_wdata = 8'h44; bus.file_we = 1'b1;
      bus.ext_addr = 16'h0030;  bus.ext_wdata = 8'h44;  bus.ext_we = 1'b1; bus.ext_re = 1'b1;
      repeat (3) step();
      extRead(16'h0030);

      // Read during write returns old data
      extWrite(16'h0005, 8'h11);
      bus.ext_addr = 16'h0005; bus.ext_wdata = 8'h22; bus.ext_we = 1'b1; bus.ext_re = 1'b1;
      step();
      extRead(16'h0005);

      // Streaming writes then readback on the decompressor channel
      step();
      step();
      startPulses = writePulses;
      for (int i = 0; i < 256; i++) begin
         clearInputs();
         bus.load = 1'b1;
         bus.dec_addr = 16'(i); bus.dec_wdata = 8'(i); bus.dec_we = 1'b1;
         step();
      end
      clearInputs();
      step();
      step();
      check("stream_write_pulses", 32'(writePulses - startPulses), 32'd256);
      for (int i = 0; i < 256; i++) begin
         clearInputs();
         bus.load = 1'b1;
         bus.dec_addr = 16'(i); bus.dec_re = 1'b1;
         step();
      end

      // Reset asserted in the middle of a decompressor write
      clearInputs();
      bus.load = 1'b1;
      bus.dec_addr = 16'h0040; bus.dec_re = 1'b1;
      step();
      check("pre_reset_done_read", 32'(bus.done_read), 32'h1);
      check("pre_reset_rdata", 32'(bus.ram_rdata), 32'h40);
      bus.dec_re = 1'b0;
      bus.dec_wdata = 8'h77; bus.dec_we = 1'b1;
      #1;
      RST = 1'b0;
      expQ.delete();
      #1;
      check("async_reset_rdata", 32'(bus.ram_rdata), 32'h0);
      check("async_reset_done_read", 32'(bus.done_read), 32'h0);
      check("async_reset_done_write", 32'(bus.done_write), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      clearInputs();
      RST = 1'b1;
      bus.load = 1'b1;
      bus.dec_addr = 16'h0040; bus.dec_re = 1'b1;
      step();
      clearInputs();

      // Randomized traffic with mode changes every cycle
      for (int n = 0; n < 400; n++) begin
         logic [1:0] m;
         m = 2'($urandom_range(0, 3));
         bus.load = m[1]; bus.cnn = m[0];
         bus.dec_addr = 16'($urandom_range(0, 255));  bus.dec_wdata = 8'($urandom);
         bus.dec_we = 1'($urandom);  bus.dec_re = 1'($urandom);
         bus.file_addr = 16'($urandom_range(0, 255)); bus.file_wdata = 8'($urandom);
         bus.file_we = 1'($urandom);
         bus.ext_addr = 16'($urandom_range(0, 255));  bus.ext_wdata = 8'($urandom);
         bus.ext_we = 1'($urandom);  bus.ext_re = 1'($urandom);
         step();
      end
      clearInputs();
      repeat (3) step();
      check("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
